// File: rtl/imm_ext_pkg.sv
// Shared types and default widths for the immediate-extension unit.
// Optional skid buffer in imm_extend_pipe is enabled with IMM_EXT_SKID_EN.
package imm_ext_pkg;

    typedef enum logic [1:0] {
        IMM_MODE_SIGN   = 2'd0,
        IMM_MODE_ZERO   = 2'd1,
        IMM_MODE_UPPER  = 2'd2,
        IMM_MODE_BRANCH = 2'd3
    } imm_mode_e;

    // Occupancy of the one-entry skid register (skid build only).
    typedef enum logic {
        SKID_EMPTY = 1'b0,
        SKID_FULL  = 1'b1
    } skid_state_e;

    localparam int IMM_IN_WIDTH_DEF  = 16;
    localparam int IMM_OUT_WIDTH_DEF = 32;
    localparam int IMM_TAG_WIDTH_DEF = 5;

endpackage

// File: rtl/imm_ext_core.sv
// Purely combinational immediate extender: widens an IN_WIDTH field to
// OUT_WIDTH in sign, zero, upper-placement or branch-offset form.
module imm_ext_core
    import imm_ext_pkg::*;
#(
    parameter int IN_WIDTH  = IMM_IN_WIDTH_DEF,
    parameter int OUT_WIDTH = IMM_OUT_WIDTH_DEF
) (
    input  logic [IN_WIDTH-1:0]  in_data_i,
    input  imm_mode_e            in_mode_i,
    output logic [OUT_WIDTH-1:0] ext_o
);

    logic [OUT_WIDTH-1:0] sign_ext;
    logic [OUT_WIDTH-1:0] zero_ext;
    logic [OUT_WIDTH-1:0] upper_ext;
    logic [OUT_WIDTH-1:0] branch_ext;

    // A zero-width pad is not legal, so equal widths get a pass-through branch.
    generate
        if (OUT_WIDTH > IN_WIDTH) begin : g_widen
            localparam int PAD = OUT_WIDTH - IN_WIDTH;
            assign sign_ext  = {{PAD{in_data_i[IN_WIDTH-1]}}, in_data_i};
            assign zero_ext  = {{PAD{1'b0}}, in_data_i};
            assign upper_ext = {in_data_i, {PAD{1'b0}}};
        end else begin : g_equal
            assign sign_ext  = in_data_i;
            assign zero_ext  = in_data_i;
            assign upper_ext = in_data_i;
        end
    endgenerate

    assign branch_ext = {sign_ext[OUT_WIDTH-3:0], 2'b00};

    always_comb begin
        ext_o = sign_ext;
        case (in_mode_i)
            IMM_MODE_SIGN:   ext_o = sign_ext;
            IMM_MODE_ZERO:   ext_o = zero_ext;
            IMM_MODE_UPPER:  ext_o = upper_ext;
            IMM_MODE_BRANCH: ext_o = branch_ext;
            default:         ext_o = sign_ext;
        endcase
    end

endmodule

// File: rtl/imm_extend_pipe.sv
// Registered immediate extender behind a valid/ready handshake.
// Define IMM_EXT_SKID_EN to add a one-entry skid buffer and a registered in_ready_o.
module imm_extend_pipe
    import imm_ext_pkg::*;
#(
    parameter int IN_WIDTH  = IMM_IN_WIDTH_DEF,
    parameter int OUT_WIDTH = IMM_OUT_WIDTH_DEF,
    parameter int TAG_WIDTH = IMM_TAG_WIDTH_DEF
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [IN_WIDTH-1:0]  in_data_i,
    input  logic [1:0]           in_mode_i,
    input  logic [TAG_WIDTH-1:0] in_tag_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [OUT_WIDTH-1:0] out_data_o,
    output logic [TAG_WIDTH-1:0] out_tag_o
);

    logic [OUT_WIDTH-1:0] ext_data;

    imm_ext_core #(
        .IN_WIDTH  (IN_WIDTH),
        .OUT_WIDTH (OUT_WIDTH)
    ) u_core (
        .in_data_i (in_data_i),
        .in_mode_i (imm_mode_e'(in_mode_i)),
        .ext_o     (ext_data)
    );

    logic                 out_valid_q, out_valid_d;
    logic [OUT_WIDTH-1:0] out_data_q,  out_data_d;
    logic [TAG_WIDTH-1:0] out_tag_q,   out_tag_d;
    logic                 in_fire;
    logic                 out_fire;

    assign in_fire     = in_valid_i && in_ready_o;
    assign out_fire    = out_valid_q && out_ready_i;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_tag_o   = out_tag_q;

`ifdef IMM_EXT_SKID_EN

    skid_state_e          state_q, state_d;
    logic                 in_ready_q;
    logic [OUT_WIDTH-1:0] skid_data_q, skid_data_d;
    logic [TAG_WIDTH-1:0] skid_tag_q,  skid_tag_d;

    assign in_ready_o = in_ready_q;

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_tag_d   = out_tag_q;
        skid_data_d = skid_data_q;
        skid_tag_d  = skid_tag_q;
        case (state_q)
            SKID_EMPTY: begin
                if (in_fire) begin
                    // A stalled output parks the new beat in the skid.
                    if (out_valid_q && !out_ready_i) begin
                        skid_data_d = ext_data;
                        skid_tag_d  = in_tag_i;
                        state_d     = SKID_FULL;
                    end else begin
                        out_valid_d = 1'b1;
                        out_data_d  = ext_data;
                        out_tag_d   = in_tag_i;
                    end
                end else if (out_fire) begin
                    out_valid_d = 1'b0;
                end
            end
            SKID_FULL: begin
                if (out_fire) begin
                    out_data_d = skid_data_q;
                    out_tag_d  = skid_tag_q;
                    state_d    = SKID_EMPTY;
                end
            end
            default: state_d = SKID_EMPTY;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= SKID_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_tag_q   <= '0;
            skid_data_q <= '0;
            skid_tag_q  <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d == SKID_EMPTY);
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_tag_q   <= out_tag_d;
            skid_data_q <= skid_data_d;
            skid_tag_q  <= skid_tag_d;
        end
    end

`else

    // Single-slot pipe: a slot frees up in the same cycle it drains.
    assign in_ready_o = !out_valid_q || out_ready_i;

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_tag_d   = out_tag_q;
        if (in_fire) begin
            out_valid_d = 1'b1;
            out_data_d  = ext_data;
            out_tag_d   = in_tag_i;
        end else if (out_fire) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_tag_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_tag_q   <= out_tag_d;
        end
    end

`endif

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Self-checking bench for imm_extend_pipe: three instances (16->32, 8->16,
// 16->16) share one stimulus stream and are checked against a queue model.
module tb_imm_extend_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic [1:0]  in_mode = '0;
    logic [4:0]  in_tag = '0;
    logic        out_ready = 1'b0;

    logic        rdy_a, rdy_b, rdy_c;
    logic        ov_a, ov_b, ov_c;
    logic [31:0] od_a;
    logic [15:0] od_b, od_c;
    logic [4:0]  ot_a, ot_b, ot_c;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] da;
        logic [15:0] db;
        logic [15:0] dc;
        logic [4:0]  tag;
    } beat_t;

    beat_t      model_q[$];
    logic [4:0] emitted_q[$];

    always #5 clk = ~clk;

    imm_extend_pipe #(.IN_WIDTH(16), .OUT_WIDTH(32), .TAG_WIDTH(5)) dut_a (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(rdy_a),
        .in_data_i(in_data), .in_mode_i(in_mode), .in_tag_i(in_tag),
        .out_valid_o(ov_a), .out_ready_i(out_ready), .out_data_o(od_a), .out_tag_o(ot_a)
    );

    imm_extend_pipe #(.IN_WIDTH(8), .OUT_WIDTH(16), .TAG_WIDTH(5)) dut_b (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(rdy_b),
        .in_data_i(in_data[7:0]), .in_mode_i(in_mode), .in_tag_i(in_tag),
        .out_valid_o(ov_b), .out_ready_i(out_ready), .out_data_o(od_b), .out_tag_o(ot_b)
    );

    imm_extend_pipe #(.IN_WIDTH(16), .OUT_WIDTH(16), .TAG_WIDTH(5)) dut_c (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(rdy_c),
        .in_data_i(in_data), .in_mode_i(in_mode), .in_tag_i(in_tag),
        .out_valid_o(ov_c), .out_ready_i(out_ready), .out_data_o(od_c), .out_tag_o(ot_c)
    );

    // Arithmetic reference: value of the field as an integer, then widened.
    function automatic logic [63:0] ref_ext(input int iw, input int ow,
                                            input logic [15:0] d, input logic [1:0] m);
        longint unsigned mask = (64'd1 << ow) - 64'd1;
        longint unsigned u    = 64'(d) & ((64'd1 << iw) - 64'd1);
        longint unsigned s    = u[iw-1] ? (u - (64'd1 << iw)) : u;
        case (m)
            2'd0:    return s & mask;
            2'd1:    return u & mask;
            2'd2:    return (u << (ow - iw)) & mask;
            default: return (s * 4) & mask;
        endcase
    endfunction

    // One clock cycle: drive inputs, compare all outputs with the model, advance model.
    task automatic step(input logic v, input logic [15:0] d, input logic [1:0] m,
                        input logic [4:0] t, input logic ordy, output logic acc);
        logic        exp_rdy;
        logic        exp_ov;
        logic        out_fire;
        logic [63:0] ra, rb, rc;
        beat_t       nb;
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        in_mode   = m;
        in_tag    = t;
        out_ready = ordy;
        #1;
`ifdef IMM_EXT_SKID_EN
        exp_rdy = (model_q.size() < 2);
`else
        exp_rdy = (model_q.size() == 0) || ordy;
`endif
        exp_ov = (model_q.size() != 0);
        checks += 3;
        if (rdy_a !== exp_rdy) begin errors++; $display("FAIL in_ready_a: got %b expected %b", rdy_a, exp_rdy); end
        if (rdy_b !== exp_rdy) begin errors++; $display("FAIL in_ready_b: got %b expected %b", rdy_b, exp_rdy); end
        if (rdy_c !== exp_rdy) begin errors++; $display("FAIL in_ready_c: got %b expected %b", rdy_c, exp_rdy); end
        checks += 3;
        if (ov_a !== exp_ov) begin errors++; $display("FAIL out_valid_a: got %b expected %b", ov_a, exp_ov); end
        if (ov_b !== exp_ov) begin errors++; $display("FAIL out_valid_b: got %b expected %b", ov_b, exp_ov); end
        if (ov_c !== exp_ov) begin errors++; $display("FAIL out_valid_c: got %b expected %b", ov_c, exp_ov); end
        if (exp_ov) begin
            checks += 6;
            if (od_a !== model_q[0].da) begin errors++; $display("FAIL out_data_a: got %h expected %h", od_a, model_q[0].da); end
            if (od_b !== model_q[0].db) begin errors++; $display("FAIL out_data_b: got %h expected %h", od_b, model_q[0].db); end
            if (od_c !== model_q[0].dc) begin errors++; $display("FAIL out_data_c: got %h expected %h", od_c, model_q[0].dc); end
            if (ot_a !== model_q[0].tag) begin errors++; $display("FAIL out_tag_a: got %0d expected %0d", ot_a, model_q[0].tag); end
            if (ot_b !== model_q[0].tag) begin errors++; $display("FAIL out_tag_b: got %0d expected %0d", ot_b, model_q[0].tag); end
            if (ot_c !== model_q[0].tag) begin errors++; $display("FAIL out_tag_c: got %0d expected %0d", ot_c, model_q[0].tag); end
        end
        out_fire = exp_ov && ordy;
        acc      = v && exp_rdy;
        if (out_fire) emitted_q.push_back(ot_a);
        ra = ref_ext(16, 32, d, m);
        rb = ref_ext(8, 16, d, m);
        rc = ref_ext(16, 16, d, m);
        nb.da  = ra[31:0];
        nb.db  = rb[15:0];
        nb.dc  = rc[15:0];
        nb.tag = t;
        @(posedge clk);
        if (out_fire) void'(model_q.pop_front());
        if (acc) model_q.push_back(nb);
    endtask

    task automatic drain(input int n);
        logic acc;
        for (int i = 0; i < n; i++) step(1'b0, 16'h0, 2'd0, 5'd0, 1'b1, acc);
    endtask

    task automatic test_reset;
        #12;
        checks += 6;
        if (ov_a !== 1'b0) begin errors++; $display("FAIL reset_out_valid_a: got %b expected 0", ov_a); end
        if (od_a !== 32'h0) begin errors++; $display("FAIL reset_out_data_a: got %h expected 0", od_a); end
        if (ot_a !== 5'h0) begin errors++; $display("FAIL reset_out_tag_a: got %h expected 0", ot_a); end
        if (ov_b !== 1'b0) begin errors++; $display("FAIL reset_out_valid_b: got %b expected 0", ov_b); end
        if (ov_c !== 1'b0) begin errors++; $display("FAIL reset_out_valid_c: got %b expected 0", ov_c); end
        if (od_c !== 16'h0) begin errors++; $display("FAIL reset_out_data_c: got %h expected 0", od_c); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks += 3;
        if (rdy_a !== 1'b1) begin errors++; $display("FAIL reset_in_ready_a: got %b expected 1", rdy_a); end
        if (rdy_b !== 1'b1) begin errors++; $display("FAIL reset_in_ready_b: got %b expected 1", rdy_b); end
        if (rdy_c !== 1'b1) begin errors++; $display("FAIL reset_in_ready_c: got %b expected 1", rdy_c); end
    endtask

    task automatic test_modes;
        logic [15:0] vec_d [4] = '{16'h8000, 16'h8000, 16'h1234, 16'hFFFF};
        logic [31:0] vec_e [4] = '{32'hFFFF8000, 32'h00008000, 32'h12340000, 32'hFFFFFFFC};
        logic        acc;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, vec_d[i], 2'(i), 5'(i + 1), 1'b1, acc);
            #1;
            checks += 4;
            if (!acc) begin errors++; $display("FAIL mode%0d_accept: got 0 expected 1", i); end
            if (ov_a !== 1'b1) begin errors++; $display("FAIL mode%0d_valid: got %b expected 1", i, ov_a); end
            if (od_a !== vec_e[i]) begin errors++; $display("FAIL mode%0d_data: got %h expected %h", i, od_a, vec_e[i]); end
            if (ot_a !== 5'(i + 1)) begin errors++; $display("FAIL mode%0d_tag: got %0d expected %0d", i, ot_a, i + 1); end
            $display("mode %0d: in %h -> out %h tag %0d", i, vec_d[i], od_a, ot_a);
        end
        drain(2);
    endtask

    task automatic test_width_sweep;
        logic [15:0] vec_d [6] = '{16'h0080, 16'h007F, 16'h00AB, 16'h8001, 16'h8001, 16'h8001};
        logic [1:0]  vec_m [6] = '{2'd0, 2'd3, 2'd2, 2'd0, 2'd1, 2'd3};
        logic [15:0] vec_e [6] = '{16'hFF80, 16'h01FC, 16'hAB00, 16'h8001, 16'h8001, 16'h0004};
        logic [15:0] got;
        logic        acc;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, vec_d[i], vec_m[i], 5'(i + 20), 1'b1, acc);
            #1;
            got = (i < 3) ? od_b : od_c;
            checks++;
            if (got !== vec_e[i]) begin errors++; $display("FAIL width%0d_data: got %h expected %h", i, got, vec_e[i]); end
            $display("width case %0d: in %h mode %0d -> out %h", i, vec_d[i], vec_m[i], got);
        end
        drain(2);
    endtask

    task automatic test_backpressure;
        int   idx = 1;
        int   cyc = 0;
        logic acc;
        emitted_q.delete();
        while ((idx <= 6 || model_q.size() != 0) && cyc < 60) begin
            step(idx <= 6, 16'($urandom), 2'($urandom_range(0, 3)), 5'(idx), cyc >= 4, acc);
            if (acc) idx++;
            cyc++;
        end
        checks += 2;
        if (cyc >= 60) begin errors++; $display("FAIL bp_timeout: got %0d cycles expected < 60", cyc); end
        if (emitted_q.size() != 6) begin errors++; $display("FAIL bp_count: got %0d expected 6", emitted_q.size()); end
        for (int i = 0; i < emitted_q.size() && i < 6; i++) begin
            checks++;
            if (emitted_q[i] !== 5'(i + 1)) begin errors++; $display("FAIL bp_order%0d: got %0d expected %0d", i, emitted_q[i], i + 1); end
        end
        $display("backpressure: %0d beats out in %0d cycles", emitted_q.size(), cyc);
    endtask

    task automatic test_back_to_back;
        int   n_acc = 0;
        logic acc;
        emitted_q.delete();
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 16'($urandom), 2'($urandom_range(0, 3)), 5'(i + 10), 1'b1, acc);
            if (acc) n_acc++;
            if (i > 0) begin
                checks++;
                if (ov_a !== 1'b1) begin errors++; $display("FAIL b2b_valid%0d: got %b expected 1", i, ov_a); end
            end
        end
        drain(2);
        checks += 2;
        if (n_acc != 8) begin errors++; $display("FAIL b2b_accepts: got %0d expected 8", n_acc); end
        if (emitted_q.size() != 8) begin errors++; $display("FAIL b2b_emitted: got %0d expected 8", emitted_q.size()); end
        $display("back-to-back: %0d accepted, %0d emitted", n_acc, emitted_q.size());
    endtask

    task automatic test_reset_mid_stall;
        logic acc;
        for (int i = 0; i < 3; i++) step(1'b1, 16'($urandom), 2'd0, 5'(i + 1), 1'b0, acc);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checks += 4;
        if (ov_a !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b expected 0", ov_a); end
        if (od_a !== 32'h0) begin errors++; $display("FAIL midrst_data: got %h expected 0", od_a); end
        if (ot_a !== 5'h0) begin errors++; $display("FAIL midrst_tag: got %h expected 0", ot_a); end
        if (ov_c !== 1'b0) begin errors++; $display("FAIL midrst_valid_c: got %b expected 0", ov_c); end
        model_q.delete();
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks += 2;
        if (rdy_a !== 1'b1) begin errors++; $display("FAIL midrst_in_ready: got %b expected 1", rdy_a); end
        if (ov_a !== 1'b0) begin errors++; $display("FAIL midrst_after_valid: got %b expected 0", ov_a); end
        emitted_q.delete();
        drain(5);
        checks++;
        if (emitted_q.size() != 0) begin errors++; $display("FAIL midrst_ghost: got %0d beats expected 0", emitted_q.size()); end
        $display("reset mid-stall: outputs cleared, %0d ghost beats", emitted_q.size());
    endtask

    task automatic test_random;
        logic acc;
        int   n_in = 0;
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 16'($urandom), 2'($urandom_range(0, 3)),
                 5'($urandom), $urandom_range(0, 3) != 0, acc);
            if (acc) n_in++;
        end
        drain(3);
        checks++;
        if (model_q.size() != 0) begin errors++; $display("FAIL random_drain: got %0d left expected 0", model_q.size()); end
        $display("random: %0d beats accepted", n_in);
    endtask

    initial begin
        test_reset();
        test_modes();
        test_width_sweep();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_stall();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
